router_input_ctrl: RTL and testbench

- Parametrised per-input-port controller for the serial-input crossbar router.
- Captures a serial MSB-first destination address after frame_n falls, then raises a one-hot request to the destination's output arbiter.
- Waits for that arbiter's grant with a bounded timeout, then enables payload forwarding until frame_n rises.
- One instance per router input; generalises the 16-port input FSM to any power-of-two port count, and adds timeout, abort handling and drain.

---
 rtl/router_input_ctrl.sv | 178 +++++++++++++++++
 tb/tb_router_input_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/router_input_ctrl.sv
// Per-input-port controller: serial address capture, arbiter request/grant,
// grant timeout and drain. Optional busy hold-off: define BUSY_HOLDOFF_EN.
module router_input_ctrl #(
    parameter  int NUM_PORTS     = 16,
    parameter  int GRANT_TIMEOUT = 64,
    localparam int ADDR_W        = $clog2(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 din,
    input  logic                 frame_n,
    input  logic [NUM_PORTS-1:0] busy_in,
    input  logic [NUM_PORTS-1:0] grant_in,
    output logic [NUM_PORTS-1:0] request_out,
    output logic                 data_enable_out,
    output logic [ADDR_W-1:0]    address_out,
    output logic                 addr_valid_out,
    output logic                 drop_out
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR    = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;

    localparam int TW = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST =
        (GRANT_TIMEOUT > 0) ? TW'(GRANT_TIMEOUT - 1) : '0;

    logic [2:0]           state_q, state_d;
    logic [ADDR_W-1:0]    shift_q, shift_d;
    logic [ADDR_W-1:0]    bcnt_q, bcnt_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic [NUM_PORTS-1:0] req_q, req_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 valid_q, valid_d;
    logic                 drop_q, drop_d;

    logic [ADDR_W-1:0]    addr_next;
    logic                 cap;
    logic                 grant_sel;
    logic                 busy_hold;
    logic                 busy_cap;

    function automatic logic [NUM_PORTS-1:0] onehot(
        input logic [ADDR_W-1:0] a
    );
        logic [NUM_PORTS-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

    // Address bit shifted in on this edge; for a 1-bit address it is din alone
    assign addr_next = (shift_q << 1) | ADDR_W'(din);
    assign grant_sel = grant_in[addr_q];

`ifdef BUSY_HOLDOFF_EN
    assign busy_hold = busy_in[addr_q];
    assign busy_cap  = busy_in[addr_next];
`else
    logic unused_busy;
    assign unused_busy = ^busy_in;
    assign busy_hold   = 1'b0;
    assign busy_cap    = 1'b0;
`endif

    // Next-state and registered-output decode
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bcnt_d  = bcnt_q;
        tmo_d   = tmo_q;
        req_d   = req_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        drop_d  = 1'b0;
        cap     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!frame_n) begin
                    shift_d = ADDR_W'(din);
                    bcnt_d  = ADDR_W'(ADDR_W - 1);
                    if (ADDR_W == 1) cap = 1'b1;
                    else             state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (frame_n) begin
                    state_d = S_IDLE;
                    drop_d  = 1'b1;
                end else begin
                    shift_d = addr_next;
                    bcnt_d  = bcnt_q - ADDR_W'(1);
                    if (bcnt_q == ADDR_W'(1)) cap = 1'b1;
                end
            end
            S_WAIT: begin
                if (frame_n) begin
                    state_d = S_IDLE;
                    req_d   = '0;
                    addr_d  = '0;
                    valid_d = 1'b0;
                    drop_d  = 1'b1;
                end else if (grant_sel) begin
                    state_d = S_PAYLOAD;
                    req_d   = onehot(addr_q);
                end else if (busy_hold) begin
                    req_d   = '0;
                end else if (GRANT_TIMEOUT != 0 && tmo_q == TMO_LAST) begin
                    state_d = S_DRAIN;
                    req_d   = '0;
                    addr_d  = '0;
                    valid_d = 1'b0;
                    drop_d  = 1'b1;
                end else begin
                    tmo_d   = tmo_q + TW'(1);
                    req_d   = onehot(addr_q);
                end
            end
            S_PAYLOAD: begin
                if (frame_n) begin
                    state_d = S_IDLE;
                    req_d   = '0;
                    addr_d  = '0;
                    valid_d = 1'b0;
                end
            end
            S_DRAIN: begin
                if (frame_n) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                req_d   = '0;
                addr_d  = '0;
                valid_d = 1'b0;
            end
        endcase
        if (cap) begin
            state_d = S_WAIT;
            req_d   = busy_cap ? '0 : onehot(addr_next);
            addr_d  = addr_next;
            valid_d = 1'b1;
            tmo_d   = '0;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            bcnt_q  <= '0;
            tmo_q   <= '0;
            req_q   <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bcnt_q  <= bcnt_d;
            tmo_q   <= tmo_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    assign request_out     = req_q;
    assign address_out     = addr_q;
    assign addr_valid_out  = valid_q;
    assign drop_out        = drop_q;
    assign data_enable_out = (state_q == S_PAYLOAD);

endmodule

// File: tb/tb_router_input_ctrl.sv
// Directed bench for router_input_ctrl (NUM_PORTS=16, GRANT_TIMEOUT=8).
// Covers the BUSY_HOLDOFF_EN build when that macro is defined.
module tb_router_input_ctrl;

    logic        clk;
    logic        reset_n;
    logic        din;
    logic        frame_n;
    logic [15:0] busy_in;
    logic [15:0] grant_in;
    logic [15:0] request_out;
    logic        data_enable_out;
    logic [3:0]  address_out;
    logic        addr_valid_out;
    logic        drop_out;

    int n_tests = 0;
    int n_fail  = 0;

    router_input_ctrl #(
        .NUM_PORTS    (16),
        .GRANT_TIMEOUT(8)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .din            (din),
        .frame_n        (frame_n),
        .busy_in        (busy_in),
        .grant_in       (grant_in),
        .request_out    (request_out),
        .data_enable_out(data_enable_out),
        .address_out    (address_out),
        .addr_valid_out (addr_valid_out),
        .drop_out       (drop_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Shift a 4-bit address MSB first; request must stay low until the LSB edge
    task automatic send_addr(input logic [3:0] a);
        for (int i = 3; i >= 0; i--) begin
            frame_n = 1'b0;
            din     = a[i];
            step();
            if (i > 0) chk("addr_phase_req", 32'(request_out), 32'h0);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        din      = 1'b0;
        frame_n  = 1'b1;
        busy_in  = '0;
        grant_in = '0;
        step();
        step();
        chk("rst_req", 32'(request_out), 32'h0);
        chk("rst_de", 32'(data_enable_out), 32'h0);
        chk("rst_addr", 32'(address_out), 32'h0);
        chk("rst_valid", 32'(addr_valid_out), 32'h0);
        chk("rst_drop", 32'(drop_out), 32'h0);
        reset_n = 1'b1;
        step();
        chk("idle_req", 32'(request_out), 32'h0);

        // Packet to 11, grant after two wait cycles, 5 payload bits
        send_addr(4'b1011);
        chk("t1_req", 32'(request_out), 32'h0800);
        chk("t1_addr", 32'(address_out), 32'd11);
        chk("t1_valid", 32'(addr_valid_out), 32'h1);
        chk("t1_de0", 32'(data_enable_out), 32'h0);
        step();
        step();
        chk("t1_wait_de", 32'(data_enable_out), 32'h0);
        chk("t1_wait_req", 32'(request_out), 32'h0800);
        grant_in = 16'h0800;
        step();
        chk("t1_pl_de", 32'(data_enable_out), 32'h1);
        grant_in = '0;
        for (int k = 0; k < 4; k++) begin
            frame_n = 1'b0;
            din     = k[0];
            step();
            chk("t1_pl_de", 32'(data_enable_out), 32'h1);
            chk("t1_pl_req", 32'(request_out), 32'h0800);
        end
        frame_n = 1'b1;
        step();
        chk("t1_end_de", 32'(data_enable_out), 32'h0);
        chk("t1_end_req", 32'(request_out), 32'h0);
        chk("t1_end_addr", 32'(address_out), 32'h0);
        chk("t1_end_valid", 32'(addr_valid_out), 32'h0);
        chk("t1_end_drop", 32'(drop_out), 32'h0);

        // Packet to 3 back-to-back, no grant: timeout after 8 cycles
        send_addr(4'd3);
        chk("t2_req", 32'(request_out), 32'h0008);
        for (int k = 1; k <= 7; k++) begin
            step();
            chk("t2_wait_req", 32'(request_out), 32'h0008);
            chk("t2_wait_drop", 32'(drop_out), 32'h0);
        end
        step();
        chk("t2_drop", 32'(drop_out), 32'h1);
        chk("t2_drop_req", 32'(request_out), 32'h0);
        chk("t2_drop_valid", 32'(addr_valid_out), 32'h0);
        chk("t2_drop_de", 32'(data_enable_out), 32'h0);
        for (int k = 0; k < 5; k++) begin
            din = 1'b1;
            step();
            chk("t2_drain_req", 32'(request_out), 32'h0);
            chk("t2_drain_drop", 32'(drop_out), 32'h0);
            chk("t2_drain_de", 32'(data_enable_out), 32'h0);
        end
        frame_n = 1'b1;
        step();
        chk("t2_idle_drop", 32'(drop_out), 32'h0);

        // Packet to 5, wrong-port grant ignored, then right grant
        send_addr(4'd5);
        chk("t3_req", 32'(request_out), 32'h0020);
        grant_in = 16'h0040;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t3_wrong_de", 32'(data_enable_out), 32'h0);
            chk("t3_wrong_req", 32'(request_out), 32'h0020);
        end
        grant_in = 16'h0020;
        step();
        chk("t3_pl_de", 32'(data_enable_out), 32'h1);
        grant_in = '0;
        frame_n  = 1'b1;
        step();
        chk("t3_end_de", 32'(data_enable_out), 32'h0);
        chk("t3_end_req", 32'(request_out), 32'h0);

        // Abort after two address bits
        frame_n = 1'b0;
        din     = 1'b1;
        step();
        din = 1'b0;
        step();
        frame_n = 1'b1;
        step();
        chk("t4a_drop", 32'(drop_out), 32'h1);
        chk("t4a_req", 32'(request_out), 32'h0);
        chk("t4a_valid", 32'(addr_valid_out), 32'h0);
        step();
        chk("t4a_drop_once", 32'(drop_out), 32'h0);
        chk("t4a_de", 32'(data_enable_out), 32'h0);

        // Abort in WAIT_GRANT coinciding with the grant
        send_addr(4'd9);
        chk("t4b_req", 32'(request_out), 32'h0200);
        frame_n  = 1'b1;
        grant_in = 16'h0200;
        step();
        chk("t4b_drop", 32'(drop_out), 32'h1);
        chk("t4b_de", 32'(data_enable_out), 32'h0);
        chk("t4b_req0", 32'(request_out), 32'h0);
        chk("t4b_valid", 32'(addr_valid_out), 32'h0);
        grant_in = '0;
        step();
        chk("t4b_de2", 32'(data_enable_out), 32'h0);
        chk("t4b_drop2", 32'(drop_out), 32'h0);

        // Reset mid-payload, then a packet to 0
        send_addr(4'd2);
        grant_in = 16'h0004;
        step();
        chk("t5_pl_de", 32'(data_enable_out), 32'h1);
        grant_in = '0;
        reset_n  = 1'b0;
        frame_n  = 1'b0;
        step();
        chk("t5_rst_req", 32'(request_out), 32'h0);
        chk("t5_rst_de", 32'(data_enable_out), 32'h0);
        chk("t5_rst_addr", 32'(address_out), 32'h0);
        chk("t5_rst_valid", 32'(addr_valid_out), 32'h0);
        chk("t5_rst_drop", 32'(drop_out), 32'h0);
        reset_n = 1'b1;
        send_addr(4'd0);
        chk("t5_req", 32'(request_out), 32'h0001);
        chk("t5_addr", 32'(address_out), 32'h0);
        chk("t5_valid", 32'(addr_valid_out), 32'h1);
        chk("t5_drop", 32'(drop_out), 32'h0);
        grant_in = 16'h0001;
        step();
        chk("t5_pl_de2", 32'(data_enable_out), 32'h1);
        grant_in = '0;
        frame_n  = 1'b1;
        step();
        chk("t5_end_de", 32'(data_enable_out), 32'h0);
        chk("t5_end_drop", 32'(drop_out), 32'h0);

`ifdef BUSY_HOLDOFF_EN
        // Busy destination: request withheld and timeout frozen
        busy_in = 16'h0080;
        send_addr(4'd7);
        chk("t6_busy_req", 32'(request_out), 32'h0);
        chk("t6_busy_addr", 32'(address_out), 32'd7);
        for (int k = 0; k < 9; k++) begin
            step();
            chk("t6_busy_req", 32'(request_out), 32'h0);
            chk("t6_busy_drop", 32'(drop_out), 32'h0);
        end
        busy_in = '0;
        step();
        chk("t6_free_req", 32'(request_out), 32'h0080);
        chk("t6_free_drop", 32'(drop_out), 32'h0);
        grant_in = 16'h0080;
        step();
        chk("t6_pl_de", 32'(data_enable_out), 32'h1);
        grant_in = '0;
        frame_n  = 1'b1;
        step();
        chk("t6_end_req", 32'(request_out), 32'h0);
`else
        // Busy flags have no effect on the request
        busy_in = 16'h0080;
        send_addr(4'd7);
        chk("t6_req", 32'(request_out), 32'h0080);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("t6_hold_req", 32'(request_out), 32'h0080);
        end
        busy_in = '0;
        frame_n = 1'b1;
        step();
        chk("t6_abort_drop", 32'(drop_out), 32'h1);
        chk("t6_abort_req", 32'(request_out), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
